// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// FSM states, access-size encodings and the captured request bundle.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        unsgn;
        logic [31:0] data;
    } req_t;

    // Illegal size counts as a fault just like a misaligned access.
    function automatic logic bad_access(
        input logic [1:0] size,
        input logic [1:0] offset
    );
        logic bad;
        unique case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extraction/extension and
// read-modify-write merging of sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        unsgn,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] data,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = word[{offset, 3'b000} +: 8];
    assign lane_h = word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        load_data  = '0;
        store_word = word;
        unique case (size)
            SIZE_BYTE: begin
                load_data = {{24{~unsgn & lane_b[7]}}, lane_b};
                store_word[{offset, 3'b000} +: 8] = data[7:0];
            end
            SIZE_HALF: begin
                load_data = {{16{~unsgn & lane_h[15]}}, lane_h};
                store_word[{offset[1], 4'b0000} +: 16] = data[15:0];
            end
            SIZE_WORD: begin
                load_data  = word;
                store_word = data;
            end
            default: begin
                load_data  = '0;
                store_word = word;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between CPU request port and a
// word-wide combinational-read data memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [1:0]            reqSize,
    input  logic                  reqUnsigned,
    input  logic [ADDR_WIDTH-1:0] reqAddress,
    input  logic [31:0]           reqData,
    output logic                  respValid,
    output logic [31:0]           respData,
    output logic                  respError,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [31:0]           memDataIn,
    output logic                  memWriteEnable,
    input  logic [31:0]           memDataOut
);

    state_t                state;
    req_t                  cap;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [31:0]           cap_word;
    logic [31:0]           align_word;
    logic [31:0]           load_data;
    logic [31:0]           store_word;
    logic                  in_mem;

    assign reqReady = (state == IDLE);
    assign in_mem   = (state == READ) || (state == WRITE);

    assign memAddress = in_mem
        ? {cap_addr[ADDR_WIDTH-1:2], 2'b00}
        : '0;

    assign memWriteEnable = (state == WRITE) && !reset;
    assign memDataIn      = (state == WRITE) ? store_word : '0;

    // Loads extend straight from memory; stores merge into the saved word.
    assign align_word = (state == READ) ? memDataOut : cap_word;

    lsu_lane_align u_align (
        .size       (cap.size),
        .unsgn      (cap.unsgn),
        .offset     (cap_addr[1:0]),
        .word       (align_word),
        .data       (cap.data),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cap       <= '0;
            cap_addr  <= '0;
            cap_word  <= '0;
            respValid <= 1'b0;
            respData  <= '0;
            respError <= 1'b0;
        end else begin
            respValid <= 1'b0;
            respData  <= '0;
            respError <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (reqValid) begin
                        cap <= '{
                            write: reqWrite,
                            size:  reqSize,
                            unsgn: reqUnsigned,
                            data:  reqData
                        };
                        cap_addr <= reqAddress;
                        if (bad_access(reqSize, reqAddress[1:0])) begin
                            state     <= RESP;
                            respValid <= 1'b1;
                            respError <= 1'b1;
                        end else if (reqWrite && reqSize == SIZE_WORD) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    cap_word <= memDataOut;
                    if (cap.write) begin
                        state <= WRITE;
                    end else begin
                        state     <= RESP;
                        respValid <= 1'b1;
                        respData  <= load_data;
                    end
                end
                WRITE: begin
                    state     <= RESP;
                    respValid <= 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, multi-cycle
// sequences and random traffic against a byte-array model.
module tb_load_store_unit;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          reqValid;
    logic          reqReady;
    logic          reqWrite;
    logic [1:0]    reqSize;
    logic          reqUnsigned;
    logic [AW-1:0] reqAddress;
    logic [31:0]   reqData;
    logic          respValid;
    logic [31:0]   respData;
    logic          respError;
    logic [AW-1:0] memAddress;
    logic [31:0]   memDataIn;
    logic          memWriteEnable;
    logic [31:0]   memDataOut;

    logic [31:0] mem [16] = '{default: 32'h0};
    logic [7:0]  rb  [64] = '{default: 8'h0};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqWrite       (reqWrite),
        .reqSize        (reqSize),
        .reqUnsigned    (reqUnsigned),
        .reqAddress     (reqAddress),
        .reqData        (reqData),
        .respValid      (respValid),
        .respData       (respData),
        .respError      (respError),
        .memAddress     (memAddress),
        .memDataIn      (memDataIn),
        .memWriteEnable (memWriteEnable),
        .memDataOut     (memDataOut)
    );

    assign memDataOut = mem[memAddress[5:2]];

    always @(posedge clk)
        if (memWriteEnable) mem[memAddress[5:2]] <= memDataIn;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] ed;
        logic        ee;
        int          el;
    } vec_t;

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: memory as 64 bytes, sizes as byte counts.
    task automatic model(input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a,
                         input logic [31:0] d,
                         output logic [31:0] ed, output logic ee,
                         output int el, output int ewe);
        int n;
        int idx;
        logic [31:0] v;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        idx = int'(a[5:0]);
        ee  = (sz == 2'd3) || (idx % n != 0);
        ed  = '0;
        el  = 1;
        ewe = 0;
        if (!ee) begin
            if (w) begin
                for (int i = 0; i < n; i++) rb[idx + i] = d[8*i +: 8];
                el  = (n == 4) ? 2 : 3;
                ewe = 1;
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = rb[idx + i];
                if (!u && n < 4 && v[8*n-1])
                    for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
                ed = v;
                el = 2;
            end
        end
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a,
                          input logic [31:0] d,
                          output logic [31:0] rd, output logic re,
                          output int lat, output int wes);
        bit got;
        got = 0; rd = '0; re = 1'b0; lat = 0; wes = 0;
        @(negedge clk);
        reqValid = 1'b1; reqWrite = w; reqSize = sz;
        reqUnsigned = u; reqAddress = a; reqData = d;
        @(posedge clk);
        #1;
        reqValid    = 1'b0;
        reqWrite    = 1'($urandom);
        reqSize     = 2'($urandom);
        reqUnsigned = 1'($urandom);
        reqAddress  = $urandom;
        reqData     = $urandom;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (memWriteEnable) wes++;
            if (respValid) begin
                got = 1; rd = respData; re = respError;
            end
        end
        if (!got) lat = 99;
        @(negedge clk);
        if (memWriteEnable) wes++;
        check("resp_one_cycle", 32'(respValid), 32'd0);
        check("ready_after_resp", 32'(reqReady), 32'd1);
    endtask

    task automatic run_one(input vec_t v, input bit use_tab,
                           input string tag);
        logic [31:0] md, rd;
        logic me, re;
        int ml, mwe, lat, wes;
        model(v.w, v.sz, v.u, v.a, v.d, md, me, ml, mwe);
        do_req(v.w, v.sz, v.u, v.a, v.d, rd, re, lat, wes);
        if (use_tab) begin
            md = v.ed; me = v.ee; ml = v.el;
        end
        check({tag, "_data"}, rd, md);
        check({tag, "_error"}, 32'(re), 32'(me));
        check({tag, "_latency"}, lat, ml);
        check({tag, "_we_cycles"}, wes, mwe);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tab [22];
        vec_t bb [3];
        vec_t rv;
        logic [31:0] bd [3];
        int bl [3];
        int acc [3];
        int rsp [3];
        logic [31:0] rdat [3];
        logic rerr [3];
        int idx, nr, nresp, dummy_l, dummy_w;
        logic rdy, dummy_e;

        tab[0]  = '{1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 2};
        tab[1]  = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 2};
        tab[2]  = '{1'b1, 2'd0, 1'b0, 32'h9, 32'h42, 32'h0, 1'b0, 3};
        tab[3]  = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'hDEAD42EF, 1'b0, 2};
        tab[4]  = '{1'b1, 2'd2, 1'b0, 32'h8, 32'h80011234, 32'h0, 1'b0, 2};
        tab[5]  = '{1'b0, 2'd0, 1'b0, 32'hB, 32'h0, 32'hFFFFFF80, 1'b0, 2};
        tab[6]  = '{1'b0, 2'd0, 1'b1, 32'hB, 32'h0, 32'h00000080, 1'b0, 2};
        tab[7]  = '{1'b0, 2'd1, 1'b0, 32'hA, 32'h0, 32'hFFFF8001, 1'b0, 2};
        tab[8]  = '{1'b0, 2'd1, 1'b1, 32'hA, 32'h0, 32'h00008001, 1'b0, 2};
        tab[9]  = '{1'b0, 2'd2, 1'b1, 32'h8, 32'h0, 32'h80011234, 1'b0, 2};
        tab[10] = '{1'b1, 2'd1, 1'b0, 32'h5, 32'hFFFF, 32'h0, 1'b1, 1};
        tab[11] = '{1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 1};
        tab[12] = '{1'b1, 2'd3, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, 1};
        tab[13] = '{1'b0, 2'd3, 1'b0, 32'h4, 32'h0, 32'h0, 1'b1, 1};
        tab[14] = '{1'b1, 2'd1, 1'b0, 32'h6, 32'hFFFFABCD, 32'h0, 1'b0, 3};
        tab[15] = '{1'b1, 2'd0, 1'b0, 32'h4, 32'h0000005A, 32'h0, 1'b0, 3};
        tab[16] = '{1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'hABCD005A, 1'b0, 2};
        tab[17] = '{1'b0, 2'd0, 1'b0, 32'h9, 32'h0, 32'h00000012, 1'b0, 2};
        tab[18] = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h80011234, 1'b0, 2};
        tab[19] = '{1'b1, 2'd1, 1'b0, 32'h2, 32'h1234AAAA, 32'h0, 1'b0, 3};
        tab[20] = '{1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 32'hFFFFAAAA, 1'b0, 2};
        tab[21] = '{1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'hAAAA0000, 1'b0, 2};

        reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'd0;
        reqUnsigned = 1'b0; reqAddress = '0; reqData = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(reqReady), 32'd1);
        check("rst_resp_valid", 32'(respValid), 32'd0);
        check("rst_resp_data", respData, 32'd0);
        check("rst_resp_error", 32'(respError), 32'd0);
        check("rst_mem_we", 32'(memWriteEnable), 32'd0);
        check("rst_mem_addr", memAddress, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 22; i++)
            run_one(tab[i], 1'b1, $sformatf("tab%0d", i));

        // Reset while a byte store sits in WRITE.
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd0;
        reqUnsigned = 1'b0; reqAddress = 32'h10; reqData = 32'h77;
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_write", 32'(memWriteEnable), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_we_forced", 32'(memWriteEnable), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ready", 32'(reqReady), 32'd1);
        nresp = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (respValid || memWriteEnable) nresp++;
        end
        check("abort_no_activity", nresp, 32'd0);
        check("abort_no_write", mem[4], 32'd0);

        // Back-to-back with reqValid held high.
        bb[0] = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, 0};
        bb[1] = '{1'b1, 2'd0, 1'b0, 32'h9, 32'h99, 32'h0, 1'b0, 0};
        bb[2] = '{1'b1, 2'd2, 1'b0, 32'hC, 32'h11223344, 32'h0, 1'b0, 0};
        for (int i = 0; i < 3; i++) begin
            model(bb[i].w, bb[i].sz, bb[i].u, bb[i].a, bb[i].d,
                  bd[i], dummy_e, bl[i], dummy_w);
            acc[i] = -100; rsp[i] = -200;
            rdat[i] = '1; rerr[i] = 1'b1;
        end
        idx = 0; nr = 0;
        @(negedge clk);
        reqValid = 1'b1; reqWrite = bb[0].w; reqSize = bb[0].sz;
        reqUnsigned = bb[0].u; reqAddress = bb[0].a; reqData = bb[0].d;
        for (int c = 0; c < 40 && nr < 3; c++) begin
            rdy = reqReady;
            if (respValid) begin
                rsp[nr] = c; rdat[nr] = respData;
                rerr[nr] = respError; nr++;
            end
            @(posedge clk);
            if (rdy && idx < 3) begin
                acc[idx] = c;
                idx++;
                #1;
                if (idx < 3) begin
                    reqWrite = bb[idx].w; reqSize = bb[idx].sz;
                    reqUnsigned = bb[idx].u; reqAddress = bb[idx].a;
                    reqData = bb[idx].d;
                end else begin
                    reqValid = 1'b0;
                end
            end
            @(negedge clk);
        end
        reqValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b%0d_latency", i), rsp[i] - acc[i], bl[i]);
            check($sformatf("b2b%0d_data", i), rdat[i], bd[i]);
            check($sformatf("b2b%0d_error", i), 32'(rerr[i]), 32'd0);
            if (i < 2)
                check($sformatf("b2b%0d_gap", i), acc[i+1] - rsp[i], 1);
        end

        // Random traffic against the byte model.
        for (int i = 0; i < 300; i++) begin
            rv.w  = 1'($urandom);
            rv.sz = 2'($urandom);
            rv.u  = 1'($urandom);
            rv.a  = 32'($urandom_range(0, 63));
            rv.d  = $urandom;
            rv.ed = '0; rv.ee = 1'b0; rv.el = 0;
            run_one(rv, 1'b0, $sformatf("rnd%0d", i));
        end

        for (int i = 0; i < 16; i++)
            check($sformatf("mem%0d", i), mem[i],
                  {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]});

        dummy_l = 0;
        if (dummy_l != 0) $display("unused");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
